// File: rtl/l2cache_pkg.sv
// Shared types and constants for the L2 tag/valid array sequencer.
package l2cache_pkg;

  localparam int L2_WAY      = 8;
  localparam int L2_WAY_BITS = 3;

  localparam logic INV_MODE_IDX = 1'b0;
  localparam logic INV_MODE_HIT = 1'b1;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    IDLE     = 2'd1,
    INV_LOOK = 2'd2,
    INV_CHK  = 2'd3
  } state_e;

  function automatic logic [L2_WAY-1:0] way_onehot(input logic [L2_WAY_BITS-1:0] w);
    way_onehot    = '0;
    way_onehot[w] = 1'b1;
  endfunction

endpackage

// File: rtl/l2cache_tagv_ctrl_if.sv
// Bundle between the tag/valid sequencer, its clients (pipeline, refill, cacop/flush) and the TagV array.
interface l2cache_tagv_ctrl_if #(
  parameter int addr_width = 4,
  parameter int data_width = 25,
  parameter int way        = 8
);

  logic                  flush_req;
  logic                  busy;
  logic                  lk_stall;
  logic [addr_width-1:0] lk_addr;
  logic [data_width-1:0] lk_tag;

  logic                  refill_valid;
  logic                  refill_ready;
  logic [addr_width-1:0] refill_set;
  logic [2:0]            refill_way;
  logic [data_width-1:0] refill_tag;

  logic                  inv_valid;
  logic                  inv_ready;
  logic                  inv_mode;
  logic [addr_width-1:0] inv_set;
  logic [2:0]            inv_way;
  logic [data_width-1:0] inv_tag;
  logic                  inv_done;
  logic                  inv_hit;

  logic [addr_width-1:0] tagv_addr_read;
  logic [data_width-1:0] tagv_din_compare;
  logic [way-1:0]        tagv_hit;
  logic [3:0]            tagv_init;
  logic [addr_width-1:0] tagv_addr_write;
  logic [data_width-1:0] tagv_din_write;
  logic [way-1:0]        tagv_we;
  logic [way-1:0]        tagv_unvalid;

  // Environment side: pipeline, refill engine, cacop/flush logic and the array model.
  modport master (
    output flush_req, lk_addr, lk_tag,
    output refill_valid, refill_set, refill_way, refill_tag,
    output inv_valid, inv_mode, inv_set, inv_way, inv_tag,
    output tagv_hit,
    input  busy, lk_stall, refill_ready, inv_ready, inv_done, inv_hit,
    input  tagv_addr_read, tagv_din_compare, tagv_init,
    input  tagv_addr_write, tagv_din_write, tagv_we, tagv_unvalid
  );

  modport slave (
    input  flush_req, lk_addr, lk_tag,
    input  refill_valid, refill_set, refill_way, refill_tag,
    input  inv_valid, inv_mode, inv_set, inv_way, inv_tag,
    input  tagv_hit,
    output busy, lk_stall, refill_ready, inv_ready, inv_done, inv_hit,
    output tagv_addr_read, tagv_din_compare, tagv_init,
    output tagv_addr_write, tagv_din_write, tagv_we, tagv_unvalid
  );

endinterface

// File: rtl/l2cache_tagv_init_walker.sv
// Set/way counter pair that walks the whole array one way per step; done marks the final way of the final set.
module l2cache_tagv_init_walker
  import l2cache_pkg::*;
#(
  parameter int addr_width = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   step,
  output logic [addr_width-1:0]  set_cnt,
  output logic [L2_WAY_BITS-1:0] way_cnt,
  output logic                   done
);

  // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      set_cnt <= '0;
      way_cnt <= '0;
    end else if (step) begin
      way_cnt <= way_cnt + 1'b1;
      if (&way_cnt) set_cnt <= set_cnt + 1'b1;
    end
  end

  assign done = (&set_cnt) & (&way_cnt);

endmodule

// File: rtl/l2cache_tagv_ctrl.sv
// Tag/valid array sequencer: post-reset/flush clear walk, refill writes and both invalidate flavours.
module l2cache_tagv_ctrl
  import l2cache_pkg::*;
#(
  parameter int addr_width = 4,
  parameter int data_width = 25,
  parameter int way        = L2_WAY
) (
  input logic              clk,
  input logic              rst,
  l2cache_tagv_ctrl_if.slave bus
);

  localparam logic [1:0] S_INIT     = INIT;
  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_INV_LOOK = INV_LOOK;
  localparam logic [1:0] S_INV_CHK  = INV_CHK;

  logic [1:0]             state, state_nxt;
  logic                   flush_pend;
  logic                   idx_done;
  logic [addr_width-1:0]  lat_set;
  logic [data_width-1:0]  lat_tag;

  logic [addr_width-1:0]  set_cnt;
  logic [L2_WAY_BITS-1:0] way_cnt;
  logic                   walk_done;

  logic in_idle, in_inv, go_flush;
  logic refill_ready, inv_ready;
  logic refill_fire, inv_fire, idx_fire, hit_fire;

  logic [3:0]            tagv_init;
  logic [addr_width-1:0] tagv_addr_write;
  logic [data_width-1:0] tagv_din_write;
  logic [L2_WAY-1:0]     tagv_we, tagv_unvalid;
  logic                  inv_done, inv_hit;

  assign in_idle = (state == S_IDLE);
  assign in_inv  = (state == S_INV_LOOK) || (state == S_INV_CHK);

  // Flush outranks everything: a request seen in IDLE blocks both handshakes this cycle.
  assign go_flush     = in_idle & (bus.flush_req | flush_pend);
  assign refill_ready = in_idle & ~bus.flush_req & ~flush_pend;
  assign inv_ready    = refill_ready & ~bus.refill_valid;

  assign refill_fire = bus.refill_valid & refill_ready;
  assign inv_fire    = bus.inv_valid & inv_ready;
  assign idx_fire    = inv_fire & (bus.inv_mode == INV_MODE_IDX);
  assign hit_fire    = inv_fire & (bus.inv_mode == INV_MODE_HIT);

  l2cache_tagv_init_walker #(
    .addr_width(addr_width)
  ) u_walker (
    .clk    (clk),
    .rst    (rst),
    .clear  (go_flush),
    .step   (state == S_INIT),
    .set_cnt(set_cnt),
    .way_cnt(way_cnt),
    .done   (walk_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:     if (walk_done) state_nxt = S_IDLE;
      S_IDLE: begin
        if (go_flush)      state_nxt = S_INIT;
        else if (hit_fire) state_nxt = S_INV_LOOK;
      end
      S_INV_LOOK: state_nxt = S_INV_CHK;
      S_INV_CHK:  state_nxt = S_IDLE;
      default:    state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      flush_pend <= 1'b0;
      idx_done   <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx_done <= idx_fire;
      // A flush arriving mid hit-invalidate is remembered; one arriving during the walk is moot.
      if (go_flush)
        flush_pend <= 1'b0;
      else if (bus.flush_req && in_inv)
        flush_pend <= 1'b1;
    end
  end

  // NOTE: the latched set/tag are pure data qualified by the FSM, so they carry no reset.
  always_ff @(posedge clk) begin
    if (hit_fire) begin
      lat_set <= bus.inv_set;
      lat_tag <= bus.inv_tag;
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    tagv_init       = 4'd0;
    tagv_addr_write = bus.refill_set;
    tagv_din_write  = bus.refill_tag;
    tagv_we         = '0;
    tagv_unvalid    = '0;
    inv_done        = idx_done;
    inv_hit         = idx_done;
    case (state)
      S_INIT: begin
        tagv_init       = {1'b1, way_cnt};
        tagv_addr_write = set_cnt;
      end
      S_IDLE: begin
        if (refill_fire) begin
          tagv_we = way_onehot(bus.refill_way);
        end else if (idx_fire) begin
          tagv_unvalid    = way_onehot(bus.inv_way);
          tagv_addr_write = bus.inv_set;
        end
      end
      S_INV_CHK: begin
        tagv_unvalid    = bus.tagv_hit;
        tagv_addr_write = lat_set;
        inv_done        = 1'b1;
        inv_hit         = |bus.tagv_hit;
      end
      default: ;
    endcase
  end

  assign bus.busy             = ~in_idle;
  assign bus.lk_stall         = ~in_idle;
  assign bus.refill_ready     = refill_ready;
  assign bus.inv_ready        = inv_ready;
  assign bus.inv_done         = inv_done;
  assign bus.inv_hit          = inv_hit;
  assign bus.tagv_addr_read   = in_inv ? lat_set : bus.lk_addr;
  assign bus.tagv_din_compare = in_inv ? lat_tag : bus.lk_tag;
  assign bus.tagv_init        = tagv_init;
  assign bus.tagv_addr_write  = tagv_addr_write;
  assign bus.tagv_din_write   = tagv_din_write;
  assign bus.tagv_we          = tagv_we;
  assign bus.tagv_unvalid     = tagv_unvalid;

endmodule

// File: tb/tb_l2cache_tagv_ctrl.sv
// Directed bench for l2cache_tagv_ctrl: a cycle-level behavioural model checked every cycle plus literal spot checks.
module tb_l2cache_tagv_ctrl;
  import l2cache_pkg::*;

  localparam int AW   = 4;
  localparam int DW   = 25;
  localparam int WALK = 8 * (1 << AW);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2cache_tagv_ctrl_if #(.addr_width(AW), .data_width(DW), .way(8)) bus ();

  l2cache_tagv_ctrl #(.addr_width(AW), .data_width(DW), .way(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: position in the clear walk, hit-invalidate phase (0 none, 1 look, 2 check), pending flush.
  bit              model_on = 1'b0;
  bit              m_init   = 1'b1;
  int              m_idx    = 0;
  int              m_phase  = 0;
  bit              m_pend   = 1'b0;
  bit              m_idx_done = 1'b0;
  logic [AW-1:0]   m_lat_set;
  logic [DW-1:0]   m_lat_tag;

  function automatic bit exp_busy();
    return m_init || (m_phase != 0);
  endfunction

  function automatic bit exp_rr();
    return !exp_busy() && !bus.flush_req && !m_pend;
  endfunction

  function automatic bit exp_ir();
    return exp_rr() && !bus.refill_valid;
  endfunction

  function automatic logic [7:0] exp_we();
    if (exp_rr() && bus.refill_valid) return 8'(1 << bus.refill_way);
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_uv();
    if (exp_ir() && bus.inv_valid && !bus.inv_mode) return 8'(1 << bus.inv_way);
    if (m_phase == 2) return bus.tagv_hit;
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_on   <= 1'b1;
      m_init     <= 1'b1;
      m_idx      <= 0;
      m_phase    <= 0;
      m_pend     <= 1'b0;
      m_idx_done <= 1'b0;
    end else if (model_on) begin
      m_idx_done <= exp_ir() && bus.inv_valid && !bus.inv_mode;
      if (m_init) begin
        if (m_idx == WALK - 1) begin
          m_init <= 1'b0;
          m_idx  <= 0;
        end else begin
          m_idx <= m_idx + 1;
        end
      end else if (m_phase != 0) begin
        if (bus.flush_req) m_pend <= 1'b1;
        m_phase <= (m_phase == 1) ? 2 : 0;
      end else if (bus.flush_req || m_pend) begin
        m_init <= 1'b1;
        m_idx  <= 0;
        m_pend <= 1'b0;
      end else if (exp_ir() && bus.inv_valid && bus.inv_mode) begin
        m_phase   <= 1;
        m_lat_set <= bus.inv_set;
        m_lat_tag <= bus.inv_tag;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("m_busy", 32'(bus.busy), 32'(exp_busy()));
      check("m_lk_stall", 32'(bus.lk_stall), 32'(exp_busy()));
      check("m_refill_ready", 32'(bus.refill_ready), 32'(exp_rr()));
      check("m_inv_ready", 32'(bus.inv_ready), 32'(exp_ir()));
      check("m_we", 32'(bus.tagv_we), 32'(exp_we()));
      check("m_unvalid", 32'(bus.tagv_unvalid), 32'(exp_uv()));
      check("m_we_uv_excl", 32'(bus.tagv_we & bus.tagv_unvalid), 32'd0);
      check("m_init", 32'(bus.tagv_init), m_init ? 32'(8 + m_idx % 8) : 32'd0);
      check("m_inv_done", 32'(bus.inv_done), 32'(m_idx_done || m_phase == 2));
      check("m_inv_hit", 32'(bus.inv_hit), 32'(m_idx_done || (m_phase == 2 && bus.tagv_hit != 0)));
      check("m_rd_addr", 32'(bus.tagv_addr_read), 32'((m_phase != 0) ? m_lat_set : bus.lk_addr));
      check("m_cmp_tag", 32'(bus.tagv_din_compare), 32'((m_phase != 0) ? m_lat_tag : bus.lk_tag));
      if (m_init) begin
        check("m_wr_addr_init", 32'(bus.tagv_addr_write), 32'(m_idx / 8));
      end else if (m_phase == 2) begin
        check("m_wr_addr_chk", 32'(bus.tagv_addr_write), 32'(m_lat_set));
      end else if (exp_we() != 0) begin
        check("m_wr_addr_refill", 32'(bus.tagv_addr_write), 32'(bus.refill_set));
        check("m_din_refill", 32'(bus.tagv_din_write), 32'(bus.refill_tag));
      end else if (exp_uv() != 0) begin
        check("m_wr_addr_inv", 32'(bus.tagv_addr_write), 32'(bus.inv_set));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller has already checked the walk's first n0 cycles; counts the rest until busy drops.
  task automatic walk_len(input string name, input int n0, input int flush_at);
    int n;
    n = n0;
    for (int c = 0; c < 400; c++) begin
      tick();
      bus.flush_req = (n == flush_at);
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    bus.flush_req = 1'b0;
    check(name, 32'(n), 32'(WALK));
  endtask

  task automatic hit_inv_start(input logic [AW-1:0] s, input logic [DW-1:0] t);
    tick();
    bus.inv_valid = 1'b1;
    bus.inv_mode  = INV_MODE_HIT;
    bus.inv_set   = s;
    bus.inv_tag   = t;
    @(negedge clk);
    check("hit_hs_ready", 32'(bus.inv_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit found;
    rst = 1'b1;
    bus.flush_req = 1'b0;  bus.lk_addr = 4'hA;  bus.lk_tag = 25'h0123456;
    bus.refill_valid = 1'b0; bus.refill_set = '0; bus.refill_way = '0; bus.refill_tag = '0;
    bus.inv_valid = 1'b0; bus.inv_mode = 1'b0; bus.inv_set = '0; bus.inv_way = '0; bus.inv_tag = '0;
    bus.tagv_hit = 8'h00;

    tick();
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_lk_stall", 32'(bus.lk_stall), 32'd1);
    check("rst_refill_ready", 32'(bus.refill_ready), 32'd0);
    check("rst_inv_ready", 32'(bus.inv_ready), 32'd0);
    check("rst_inv_done", 32'(bus.inv_done), 32'd0);
    check("rst_we", 32'(bus.tagv_we), 32'd0);
    check("rst_tagv_init", 32'(bus.tagv_init), 32'h8);

    // Initial walk: ways step 0..7 in set 0, then set 1.
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("walk_c0_init", 32'(bus.tagv_init), 32'h8);
    check("walk_c0_set", 32'(bus.tagv_addr_write), 32'd0);
    for (int c = 1; c < 10; c++) begin
      tick();
      @(negedge clk);
      check("walk_init", 32'(bus.tagv_init), 32'(8 + c % 8));
      check("walk_set", 32'(bus.tagv_addr_write), 32'(c / 8));
    end
    walk_len("init_len", 10, -1);
    check("ready_after_init", 32'(bus.refill_ready), 32'd1);

    // Refill beats a simultaneous invalidate; back-to-back refills.
    tick();
    bus.refill_valid = 1'b1; bus.refill_set = 4'd5; bus.refill_way = 3'd3; bus.refill_tag = 25'h1ABCDE;
    bus.inv_valid = 1'b1; bus.inv_mode = INV_MODE_HIT; bus.inv_set = 4'd5; bus.inv_tag = 25'h1ABCDE;
    @(negedge clk);
    check("refill_we", 32'(bus.tagv_we), 32'h08);
    check("refill_addr", 32'(bus.tagv_addr_write), 32'd5);
    check("refill_din", 32'(bus.tagv_din_write), 32'h1ABCDE);
    check("refill_inv_ready", 32'(bus.inv_ready), 32'd0);
    tick();
    bus.refill_set = 4'd15; bus.refill_way = 3'd7; bus.refill_tag = 25'h1FFFFFF;
    @(negedge clk);
    check("refill2_we", 32'(bus.tagv_we), 32'h80);
    check("refill2_din", 32'(bus.tagv_din_write), 32'h1FFFFFF);

    // Hit-invalidate set 5 hitting way 3 (handshake is this cycle, T).
    tick();
    bus.refill_valid = 1'b0;
    @(negedge clk);
    check("hit_hs_ready", 32'(bus.inv_ready), 32'd1);
    tick();
    bus.inv_valid = 1'b0; bus.lk_addr = 4'h3; bus.tagv_hit = 8'hFF;
    @(negedge clk);
    check("hit_look_rd", 32'(bus.tagv_addr_read), 32'd5);
    check("hit_look_cmp", 32'(bus.tagv_din_compare), 32'h1ABCDE);
    check("hit_look_done", 32'(bus.inv_done), 32'd0);
    tick();
    bus.tagv_hit = 8'h08;
    @(negedge clk);
    check("hit_chk_uv", 32'(bus.tagv_unvalid), 32'h08);
    check("hit_chk_done", 32'(bus.inv_done), 32'd1);
    check("hit_chk_hit", 32'(bus.inv_hit), 32'd1);
    tick();
    bus.tagv_hit = 8'h00;
    @(negedge clk);
    check("hit_after_busy", 32'(bus.busy), 32'd0);
    check("hit_after_rd", 32'(bus.tagv_addr_read), 32'd3);

    // Hit-invalidate that misses.
    hit_inv_start(4'd9, 25'h0ABC);
    tick();
    bus.inv_valid = 1'b0;
    tick();
    @(negedge clk);
    check("miss_done", 32'(bus.inv_done), 32'd1);
    check("miss_hit", 32'(bus.inv_hit), 32'd0);
    check("miss_uv", 32'(bus.tagv_unvalid), 32'd0);

    // Index-way invalidate set 2 way 7.
    tick();
    bus.inv_valid = 1'b1; bus.inv_mode = INV_MODE_IDX; bus.inv_set = 4'd2; bus.inv_way = 3'd7;
    @(negedge clk);
    check("idx_uv", 32'(bus.tagv_unvalid), 32'h80);
    check("idx_addr", 32'(bus.tagv_addr_write), 32'd2);
    check("idx_done_early", 32'(bus.inv_done), 32'd0);
    tick();
    bus.inv_valid = 1'b0;
    @(negedge clk);
    check("idx_done", 32'(bus.inv_done), 32'd1);
    check("idx_hit", 32'(bus.inv_hit), 32'd1);

    // Flush pulse during INV_LOOK: the lookup finishes, then a full walk; a flush during that walk is ignored.
    hit_inv_start(4'd3, 25'h55);
    tick();
    bus.inv_valid = 1'b0; bus.flush_req = 1'b1;
    @(negedge clk);
    check("fl_look_busy", 32'(bus.busy), 32'd1);
    tick();
    bus.flush_req = 1'b0; bus.tagv_hit = 8'h01;
    @(negedge clk);
    check("fl_chk_done", 32'(bus.inv_done), 32'd1);
    check("fl_chk_uv", 32'(bus.tagv_unvalid), 32'h01);
    tick();
    bus.tagv_hit = 8'h00;
    bus.refill_valid = 1'b1; bus.refill_set = 4'd1; bus.refill_way = 3'd1; bus.refill_tag = 25'h7;
    @(negedge clk);
    check("fl_pend_ready", 32'(bus.refill_ready), 32'd0);
    check("fl_pend_we", 32'(bus.tagv_we), 32'd0);
    tick();
    bus.refill_valid = 1'b0;
    @(negedge clk);
    check("fl_walk_init", 32'(bus.tagv_init), 32'h8);
    walk_len("flush_walk_len", 1, 40);
    tick();
    @(negedge clk);
    check("fl_no_rewalk", 32'(bus.busy), 32'd0);

    // Flush in IDLE, then reset at set 9.
    tick();
    bus.flush_req = 1'b1; bus.refill_valid = 1'b1;
    @(negedge clk);
    check("fl_idle_ready", 32'(bus.refill_ready), 32'd0);
    tick();
    bus.flush_req = 1'b0; bus.refill_valid = 1'b0;
    @(negedge clk);
    check("fl_idle_walk", 32'(bus.tagv_init), 32'h8);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      @(negedge clk);
      if (bus.tagv_addr_write == 4'd9 && bus.tagv_init == 4'h8) begin
        found = 1'b1;
        break;
      end
    end
    check("found_set9", 32'(found), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst9_way1", 32'(bus.tagv_init), 32'h9);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst9_restart_init", 32'(bus.tagv_init), 32'h8);
    check("rst9_restart_set", 32'(bus.tagv_addr_write), 32'd0);
    walk_len("rst9_walk_len", 1, -1);

    // Reset during INV_LOOK drops the hit-invalidate.
    hit_inv_start(4'd6, 25'h77);
    tick();
    bus.inv_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rstinv_look_done", 32'(bus.inv_done), 32'd0);
    tick();
    rst = 1'b0; bus.tagv_hit = 8'h04;
    @(negedge clk);
    check("rstinv_no_done", 32'(bus.inv_done), 32'd0);
    check("rstinv_init", 32'(bus.tagv_init), 32'h8);
    check("rstinv_busy", 32'(bus.busy), 32'd1);
    bus.tagv_hit = 8'h00;
    walk_len("rstinv_walk_len", 1, -1);
    tick();
    @(negedge clk);
    check("end_idle", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
